// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// opcode/funct values and every datapath mux select code.
package mips_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP
  } state_e;

  // Instruction class handed to the ALU decoder
  typedef enum logic [1:0] {
    ACLS_ADD,
    ACLS_SUB,
    ACLS_OR,
    ACLS_FUNCT
  } alu_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;
  localparam logic [1:0] WD_LUI = 2'b11;

  localparam logic [1:0] WA_RT = 2'b00;
  localparam logic [1:0] WA_RD = 2'b01;
  localparam logic [1:0] WA_RA = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_SIMM = 2'b01;
  localparam logic [1:0] SRCB_ZIMM = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // State entered after DECODE; FETCH means the instruction is unsupported
  function automatic state_e decode_target(input logic [5:0] op, input logic [5:0] fn);
    state_e nxt;
    nxt = S_FETCH;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: nxt = S_EXEC_R;
          FN_JR:                                 nxt = S_JUMP;
          default:                               nxt = S_FETCH;
        endcase
      end
      OP_LW, OP_SW:            nxt = S_MEM_ADDR;
      OP_ADDI, OP_ORI, OP_LUI: nxt = S_EXEC_I;
      OP_BEQ, OP_BNE:          nxt = S_BRANCH;
      OP_J, OP_JAL:            nxt = S_JUMP;
      default:                 nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// ALU operation decoder: instruction class plus funct field -> alu_ctrl.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0]  funct,
  input  alu_class_e  alu_class,
  output logic [2:0]  alu_ctrl
);

  // Pure lookup; unknown functs fall back to add
  always_comb begin
    // NOTE: assign a default before any branch so every path drives the output and no latch is inferred.
    alu_ctrl = ALU_ADD;
    case (alu_class)
      ACLS_ADD: alu_ctrl = ALU_ADD;
      ACLS_SUB: alu_ctrl = ALU_SUB;
      ACLS_OR:  alu_ctrl = ALU_OR;
      ACLS_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback and drives all datapath selects and the memory req/ack port.
// Outputs are decoded combinationally from the state register because
// several of them are Mealy terms (mem_ack in FETCH, zero in BRANCH) and
// all must fall to zero the instant rst_n is asserted.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       reg_we,
  output logic [1:0] wd_sel,
  output logic [1:0] wa_sel,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  state_e     state_q;
  alu_class_e alu_class;
  logic [2:0] alu_ctrl_dec;

  mips_alu_dec u_alu_dec (
    .funct     (funct),
    .alu_class (alu_class),
    .alu_ctrl  (alu_ctrl_dec)
  );

  // State register and transitions; memory states hold until mem_ack
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= S_RESET;
    end else begin
      case (state_q)
        S_RESET:            state_q <= S_FETCH;
        S_FETCH:            if (mem_ack) state_q <= S_DECODE;
        S_DECODE:           state_q <= decode_target(opcode, funct);
        S_EXEC_R, S_EXEC_I: state_q <= S_WB_ALU;
        S_MEM_ADDR:         state_q <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:           if (mem_ack) state_q <= S_WB_MEM;
        S_MEM_WR:           if (mem_ack) state_q <= S_FETCH;
        default:            state_q <= S_FETCH;
      endcase
    end
  end

  // Output decode; RESET drives everything, alu_ctrl included, to zero
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    reg_we    = 1'b0;
    wd_sel    = WD_ALU;
    wa_sel    = WA_RT;
    alu_src_b = SRCB_RT;
    alu_class = ACLS_ADD;
    illegal   = 1'b0;
    alu_ctrl  = alu_ctrl_dec;
    case (state_q)
      S_RESET: alu_ctrl = 3'b000;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_DECODE: illegal = (decode_target(opcode, funct) == S_FETCH);
      S_EXEC_R: alu_class = ACLS_FUNCT;
      S_EXEC_I: begin
        if (opcode == OP_ADDI) begin
          alu_src_b = SRCB_SIMM;
        end else if (opcode == OP_ORI) begin
          alu_src_b = SRCB_ZIMM;
          alu_class = ACLS_OR;
        end
      end
      S_WB_ALU: begin
        reg_we = 1'b1;
        if (opcode == OP_RTYPE) wa_sel = WA_RD;
        if (opcode == OP_LUI)   wd_sel = WD_LUI;
      end
      S_MEM_ADDR: alu_src_b = SRCB_SIMM;
      S_MEM_RD:   mem_req = 1'b1;
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_WB_MEM: begin
        reg_we = 1'b1;
        wd_sel = WD_MEM;
      end
      S_BRANCH: begin
        alu_class = ACLS_SUB;
        pc_sel    = PC_BRANCH;
        pc_we     = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_sel = (opcode == OP_RTYPE) ? PC_RS : PC_JUMP;
        if (opcode == OP_JAL) begin
          reg_we = 1'b1;
          wa_sel = WA_RA;
          wd_sel = WD_PC4;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: builds the expected per-cycle output
// trace of each instruction from the instruction's class, then replays it.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] wd_sel;
    logic [1:0] wa_sel;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t      o;
    logic       ack;
    logic       z;
    logic [5:0] op;
    logic [5:0] fn;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, ir_we, pc_we, reg_we, illegal;
  logic [1:0] pc_sel, wd_sel, wa_sel, alu_src_b;
  logic [2:0] alu_ctrl;
  outs_t      obs;

  int    checks = 0;
  int    errors = 0;
  step_t q[$];
  logic [5:0] cur_op, cur_fn;

  mips_multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .reg_we    (reg_we),
    .wd_sel    (wd_sel),
    .wa_sel    (wa_sel),
    .alu_src_b (alu_src_b),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal)
  );

  assign obs = {mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, wd_sel, wa_sel,
                alu_src_b, alu_ctrl, illegal};

  always #5 clk = ~clk;

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic outs_t idle();
    outs_t o;
    o = '0;
    o.alu_ctrl = 3'b010;
    return o;
  endfunction

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00)
      return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 ||
              fn == 6'h2A || fn == 6'h08);
    return (op == 6'h23 || op == 6'h2B || op == 6'h08 || op == 6'h0D || op == 6'h0F ||
            op == 6'h04 || op == 6'h05 || op == 6'h02 || op == 6'h03);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  task automatic push(input outs_t o, input logic ack, input logic z);
    step_t s;
    s.o = o; s.ack = ack; s.z = z; s.op = cur_op; s.fn = cur_fn;
    q.push_back(s);
  endtask

  // Expected trace of one instruction: wf/wm are cycles mem_ack is withheld
  // in fetch and in the data access, zb is the ALU zero flag for branches.
  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input int wf, input int wm, input logic zb);
    outs_t o;
    cur_op = op;
    cur_fn = fn;
    for (int i = 0; i < wf; i++) begin
      o = idle(); o.mem_req = 1'b1; push(o, 1'b0, rnd());
    end
    o = idle(); o.mem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1; push(o, 1'b1, rnd());
    o = idle(); o.illegal = !is_legal(op, fn); push(o, rnd(), rnd());
    if (!is_legal(op, fn)) return;
    if (op == 6'h00 && fn != 6'h08) begin
      o = idle(); o.alu_ctrl = funct_alu(fn); push(o, rnd(), rnd());
      o = idle(); o.reg_we = 1'b1; o.wa_sel = 2'b01; push(o, rnd(), rnd());
    end else if (op == 6'h08 || op == 6'h0D || op == 6'h0F) begin
      o = idle();
      if (op == 6'h08) o.alu_src_b = 2'b01;
      if (op == 6'h0D) begin o.alu_src_b = 2'b10; o.alu_ctrl = 3'b001; end
      push(o, rnd(), rnd());
      o = idle(); o.reg_we = 1'b1;
      if (op == 6'h0F) o.wd_sel = 2'b11;
      push(o, rnd(), rnd());
    end else if (op == 6'h23 || op == 6'h2B) begin
      o = idle(); o.alu_src_b = 2'b01; push(o, rnd(), rnd());
      for (int i = 0; i <= wm; i++) begin
        o = idle(); o.mem_req = 1'b1; o.mem_we = (op == 6'h2B);
        push(o, (i == wm), rnd());
      end
      if (op == 6'h23) begin
        o = idle(); o.reg_we = 1'b1; o.wd_sel = 2'b01; push(o, rnd(), rnd());
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      o = idle(); o.alu_ctrl = 3'b110; o.pc_sel = 2'b01;
      o.pc_we = (op == 6'h04) ? zb : !zb;
      push(o, rnd(), zb);
    end else begin
      o = idle(); o.pc_we = 1'b1;
      o.pc_sel = (op == 6'h00) ? 2'b11 : 2'b10;
      if (op == 6'h03) begin o.reg_we = 1'b1; o.wa_sel = 2'b10; o.wd_sel = 2'b10; end
      push(o, rnd(), rnd());
    end
  endtask

  // Replay the first n queued steps (one per clock), discard the rest
  task automatic run(input string tag, input int n);
    step_t s;
    int k;
    k = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      if (k < n) begin
        @(posedge clk);
        #1;
        mem_ack = s.ack; zero = s.z; opcode = s.op; funct = s.fn;
        @(negedge clk);
        checks++;
        assert (obs === s.o) else begin
          errors++;
          $error("FAIL %s step %0d op=%h fn=%h: observed %h expected %h",
                 tag, k, s.op, s.fn, obs, s.o);
        end
      end
      k++;
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert (obs === outs_t'('0)) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, outs_t'('0));
    end
  endtask

  logic [5:0] op_tab[10] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0D, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h03};
  logic [5:0] fn_tab[7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h21};

  initial begin
    logic [5:0] op, fn;
    // Reset held, then released with mem_ack already high
    repeat (2) @(negedge clk);
    check_zero("reset_held");
    mem_ack = 1'b1;
    rst_n = 1'b1;
    #1;
    check_zero("reset_state");

    build(6'h00, 6'h20, 0, 0, 1'b0); run("add", 1000);
    build(6'h23, 6'h00, 0, 3, 1'b0); run("lw_wait3", 1000);
    build(6'h04, 6'h00, 1, 0, 1'b1); run("beq_z1", 1000);
    build(6'h04, 6'h00, 0, 0, 1'b0); run("beq_z0", 1000);
    build(6'h05, 6'h00, 0, 0, 1'b1); run("bne_z1", 1000);
    build(6'h05, 6'h00, 2, 0, 1'b0); run("bne_z0", 1000);
    build(6'h03, 6'h00, 0, 0, 1'b0); run("jal", 1000);
    build(6'h00, 6'h08, 0, 0, 1'b0); run("jr", 1000);
    build(6'h3F, 6'h00, 0, 0, 1'b0); run("illegal_op", 1000);
    build(6'h0F, 6'h00, 0, 0, 1'b0); run("lui", 1000);
    build(6'h2B, 6'h00, 0, 1, 1'b0); run("sw", 1000);

    // Reset pulled in the middle of a store access
    build(6'h2B, 6'h00, 0, 5, 1'b0); run("sw_pre_reset", 4);
    #2;
    mem_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_memwr");
    @(negedge clk);
    check_zero("reset_mid_memwr_hold");
    rst_n = 1'b1;
    #1;
    check_zero("reset_after_memwr");

    // Random instruction stream with random handshake delays
    for (int i = 0; i < 150; i++) begin
      op = op_tab[$urandom_range(0, 9)];
      fn = fn_tab[$urandom_range(0, 6)];
      if ($urandom_range(0, 15) == 0) op = 6'($urandom_range(0, 63));
      build(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), rnd());
      run("random", 1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
